// File: rtl/sha256_nonce_scheduler.sv
// Issue sequencer for an unrolled SHA-256 mining pipeline: walks a nonce range one per cycle,
// tracks in-flight slots and reports hashes whose top word meets the target.
module sha256_nonce_scheduler #(
  parameter int unsigned LATENCY = 65
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         work_valid,
  output logic         work_ready,
  input  logic [255:0] work_midstate,
  input  logic [95:0]  work_data,
  input  logic [31:0]  work_nonce_start,
  input  logic [31:0]  work_nonce_end,
  input  logic [31:0]  work_target,
  input  logic         abort,
  output logic [255:0] pipe_state,
  output logic [511:0] pipe_input,
  input  logic [255:0] pipe_hash,
  output logic         golden_valid,
  input  logic         golden_ready,
  output logic [31:0]  golden_nonce,
  output logic         golden_overflow,
  output logic         busy
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e               state_q, state_d;
  logic [255:0]         midstate_q, midstate_d;
  logic [95:0]          data_q, data_d;
  logic [31:0]          target_q, target_d;
  logic [31:0]          issue_nonce_q, issue_nonce_d;
  logic [31:0]          end_q, end_d;
  logic [31:0]          out_nonce_q, out_nonce_d;
  logic [LATENCY-1:0]   valid_sr_q, valid_sr_d;
  logic [511:0]         pipe_input_q, pipe_input_d;
  logic                 golden_valid_q, golden_valid_d;
  logic [31:0]          golden_nonce_q, golden_nonce_d;
  logic                 golden_overflow_q, golden_overflow_d;

  logic issue;
  logic tail;
  logic hit;
  logic unused_hash;

  assign unused_hash = ^pipe_hash[223:0];

  assign tail = valid_sr_q[LATENCY-1];
  assign hit  = tail && (pipe_hash[255:224] <= target_q);

  always_comb begin
    state_d           = state_q;
    midstate_d        = midstate_q;
    data_d            = data_q;
    target_d          = target_q;
    issue_nonce_d     = issue_nonce_q;
    end_d             = end_q;
    out_nonce_d       = out_nonce_q;
    pipe_input_d      = pipe_input_q;
    golden_valid_d    = golden_valid_q;
    golden_nonce_d    = golden_nonce_q;
    golden_overflow_d = golden_overflow_q;
    issue             = 1'b0;

    // Results emerge in issue order, so the emerging nonce is just a counter.
    if (tail) begin
      out_nonce_d = out_nonce_q + 32'd1;
    end

    if (hit) begin
      if (!golden_valid_q || golden_ready) begin
        golden_nonce_d = out_nonce_q;
        golden_valid_d = 1'b1;
      end else begin
        golden_overflow_d = 1'b1;
      end
    end else if (golden_valid_q && golden_ready) begin
      golden_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (work_valid) begin
          midstate_d    = work_midstate;
          data_d        = work_data;
          target_d      = work_target;
          issue_nonce_d = work_nonce_start;
          out_nonce_d   = work_nonce_start;
          end_d         = work_nonce_end;
          state_d       = StRun;
        end
      end
      StRun: begin
        if (abort) begin
          state_d = StDrain;
        end else begin
          issue        = 1'b1;
          pipe_input_d = {32'h0000_0280, 320'd0, 32'h8000_0000, issue_nonce_q, data_q};
          if (issue_nonce_q == end_q) begin
            state_d = StDrain;
          end else begin
            issue_nonce_d = issue_nonce_q + 32'd1;
          end
        end
      end
      StDrain: begin
        if (valid_sr_q == '0) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    valid_sr_d = {valid_sr_q[LATENCY-2:0], issue};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= StIdle;
      midstate_q        <= '0;
      data_q            <= '0;
      target_q          <= '0;
      issue_nonce_q     <= '0;
      end_q             <= '0;
      out_nonce_q       <= '0;
      valid_sr_q        <= '0;
      pipe_input_q      <= '0;
      golden_valid_q    <= 1'b0;
      golden_nonce_q    <= '0;
      golden_overflow_q <= 1'b0;
    end else begin
      state_q           <= state_d;
      midstate_q        <= midstate_d;
      data_q            <= data_d;
      target_q          <= target_d;
      issue_nonce_q     <= issue_nonce_d;
      end_q             <= end_d;
      out_nonce_q       <= out_nonce_d;
      valid_sr_q        <= valid_sr_d;
      pipe_input_q      <= pipe_input_d;
      golden_valid_q    <= golden_valid_d;
      golden_nonce_q    <= golden_nonce_d;
      golden_overflow_q <= golden_overflow_d;
    end
  end

  assign work_ready      = (state_q == StIdle);
  assign busy            = (state_q != StIdle);
  assign pipe_state      = midstate_q;
  assign pipe_input      = pipe_input_q;
  assign golden_valid    = golden_valid_q;
  assign golden_nonce    = golden_nonce_q;
  assign golden_overflow = golden_overflow_q;

endmodule
